ps2_keycode_rx: RTL and testbench

- Keyboard front end. Receives PS/2 Set-2 scancode frames and tracks make/break and E0-extended prefixes.
- Translates a fixed key subset to USB-HID usage codes and presents the currently held key on the 8-bit keycode bus that game_state consumes.
- Also gives one-cycle press/release strobes and error strobes for debug LEDs/HEX.

---
 rtl/ps2_keycode_rx.sv | 253 +++++++++++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 Set-2 keyboard receiver: frames scancodes, tracks E0/F0 prefixes,
// maps a fixed key subset to USB-HID usages and reports the held key.
//
// Ports:
//   Clk, Reset_n        system clock, async active-low reset
//   PS2_CLK, PS2_DAT    raw keyboard lines (asynchronous to Clk)
//   keycode             HID usage of the held mapped key, 8'h00 = none
//   key_press           1-cycle strobe, keycode set to a new nonzero value
//   key_release         1-cycle strobe, keycode cleared by a break
//   parity_err          1-cycle strobe, odd-parity check failed
//   frame_err           1-cycle strobe, bad stop bit or mid-frame timeout
module ps2_keycode_rx #(
  parameter int TIMEOUT_CYC = 5000,
  parameter int CNT_W       = 13
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       key_press,
  output logic       key_release,
  output logic       parity_err,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    F_IDLE,
    F_DATA,
    F_PARITY,
    F_STOP
  } frm_e;

  typedef enum logic [1:0] {
    PREFIX_NONE,
    PREFIX_E0,
    PREFIX_F0,
    PREFIX_E0F0
  } pfx_e;

  // ---------------------------------------------------------------
  // Input synchronizers and falling-edge detect
  // ---------------------------------------------------------------
  logic [1:0] clk_s;
  logic [1:0] dat_s;
  logic       clk_d;
  logic       fall;
  logic       din;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_d <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], PS2_CLK};
      dat_s <= {dat_s[0], PS2_DAT};
      clk_d <= clk_s[1];
    end
  end

  assign fall = clk_d & ~clk_s[1];
  assign din  = dat_s[1];

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  frm_e             frm_q, frm_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shf_q, shf_d;
  logic             par_q, par_d;
  logic             stp_q, stp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             tmo;

  assign tmo = (frm_q != F_IDLE) &&
               (cnt_q == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frm_q  <= F_IDLE;
      bit_q  <= '0;
      shf_q  <= '0;
      par_q  <= 1'b0;
      stp_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      frm_q  <= frm_d;
      bit_q  <= bit_d;
      shf_q  <= shf_d;
      par_q  <= par_d;
      stp_q  <= stp_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    frm_d  = frm_q;
    bit_d  = bit_q;
    shf_d  = shf_q;
    par_d  = par_q;
    stp_d  = stp_q;
    done_d = 1'b0;

    if (frm_q == F_IDLE || fall) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (tmo) begin
      frm_d = F_IDLE;
      cnt_d = '0;
    end else if (fall) begin
      unique case (frm_q)
        F_IDLE: begin
          // Only a low start bit opens a frame.
          if (!din) begin
            frm_d = F_DATA;
            bit_d = '0;
          end
        end
        F_DATA: begin
          shf_d = {din, shf_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            frm_d = F_PARITY;
          end
        end
        F_PARITY: begin
          par_d = din;
          frm_d = F_STOP;
        end
        F_STOP: begin
          stp_d  = din;
          done_d = 1'b1;
          frm_d  = F_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Scancode decoder
  // ---------------------------------------------------------------
  function automatic logic [7:0] hid_map(
    input logic [7:0] code,
    input logic       ext
  );
    logic [7:0] h;
    case ({ext, code})
      9'h00D:  h = 8'h2B;
      9'h015:  h = 8'h14;
      9'h01C:  h = 8'h04;
      9'h023:  h = 8'h07;
      9'h01D:  h = 8'h1A;
      9'h01B:  h = 8'h16;
      9'h029:  h = 8'h2C;
      9'h05A:  h = 8'h28;
      9'h076:  h = 8'h29;
      9'h16B:  h = 8'h50;
      9'h174:  h = 8'h4F;
      9'h175:  h = 8'h52;
      9'h172:  h = 8'h51;
      default: h = 8'h00;
    endcase
    return h;
  endfunction

  pfx_e       pfx_q, pfx_d;
  logic [7:0] key_d;
  logic       press_d;
  logic       rel_d;
  logic       perr_d;
  logic       ferr_d;
  logic       par_ok;
  logic       ext;
  logic       brk;
  logic [7:0] hid;

  // Data bits plus parity bit must hold an odd number of ones.
  assign par_ok = ^{shf_q, par_q};
  assign ext    = (pfx_q == PREFIX_E0) ||
                  (pfx_q == PREFIX_E0F0);
  assign brk    = (pfx_q == PREFIX_F0) ||
                  (pfx_q == PREFIX_E0F0);
  assign hid    = hid_map(shf_q, ext);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pfx_q       <= PREFIX_NONE;
      keycode     <= 8'h00;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pfx_q       <= pfx_d;
      keycode     <= key_d;
      key_press   <= press_d;
      key_release <= rel_d;
      parity_err  <= perr_d;
      frame_err   <= ferr_d;
    end
  end

  always_comb begin
    pfx_d   = pfx_q;
    key_d   = keycode;
    press_d = 1'b0;
    rel_d   = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;

    if (tmo) begin
      // Abandoned frame: keep the held key, drop any prefix.
      ferr_d = 1'b1;
      pfx_d  = PREFIX_NONE;
    end else if (done_q) begin
      if (!par_ok || !stp_q) begin
        perr_d = !par_ok;
        ferr_d = !stp_q;
        pfx_d  = PREFIX_NONE;
      end else begin
        unique case (1'b1)
          (shf_q == 8'hE0 && pfx_q == PREFIX_NONE):
            pfx_d = PREFIX_E0;
          (shf_q == 8'hF0 && pfx_q == PREFIX_NONE):
            pfx_d = PREFIX_F0;
          (shf_q == 8'hF0 && pfx_q == PREFIX_E0):
            pfx_d = PREFIX_E0F0;
          default: begin
            pfx_d = PREFIX_NONE;
            if (hid != 8'h00) begin
              if (!brk && keycode != hid) begin
                key_d   = hid;
                press_d = 1'b1;
              end else if (brk && keycode == hid) begin
                // Only the key still shown may clear it.
                key_d = 8'h00;
                rel_d = 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: directed scenarios plus random scancode
// streams, checked against a prefix-flag / lookup-table key model.
module tb_ps2_keycode_rx;

  localparam int TMO = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] keycode;
  logic       key_press;
  logic       key_release;
  logic       parity_err;
  logic       frame_err;

  ps2_keycode_rx #(
    .TIMEOUT_CYC(TMO),
    .CNT_W      (13)
  ) dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .PS2_CLK    (ps2_clk),
    .PS2_DAT    (ps2_dat),
    .keycode    (keycode),
    .key_press  (key_press),
    .key_release(key_release),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe-high cycle counters
  int n_press = 0;
  int n_rel = 0;
  int n_perr = 0;
  int n_ferr = 0;

  always @(negedge clk) begin
    if (key_press === 1'b1) n_press <= n_press + 1;
    if (key_release === 1'b1) n_rel <= n_rel + 1;
    if (parity_err === 1'b1) n_perr <= n_perr + 1;
    if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
  end

  // Reference model
  logic [7:0] map_n [256];
  logic [7:0] map_e [256];
  logic [7:0] exp_key = 8'h00;
  int e_press = 0;
  int e_rel = 0;
  int e_perr = 0;
  int e_ferr = 0;
  bit m_ext = 0;
  bit m_brk = 0;

  task automatic init_maps();
    for (int i = 0; i < 256; i++) begin
      map_n[i] = 8'h00;
      map_e[i] = 8'h00;
    end
    map_n[8'h0D] = 8'h2B; map_n[8'h15] = 8'h14;
    map_n[8'h1C] = 8'h04; map_n[8'h23] = 8'h07;
    map_n[8'h1D] = 8'h1A; map_n[8'h1B] = 8'h16;
    map_n[8'h29] = 8'h2C; map_n[8'h5A] = 8'h28;
    map_n[8'h76] = 8'h29;
    map_e[8'h6B] = 8'h50; map_e[8'h74] = 8'h4F;
    map_e[8'h75] = 8'h52; map_e[8'h72] = 8'h51;
  endtask

  task automatic model_step(logic [7:0] b, bit pbad, bit sbad);
    logic [7:0] h;
    if (pbad || sbad) begin
      e_perr += int'(pbad);
      e_ferr += int'(sbad);
      m_ext = 0;
      m_brk = 0;
      return;
    end
    if (b == 8'hE0 && !m_ext && !m_brk) begin
      m_ext = 1;
    end else if (b == 8'hF0 && !m_brk) begin
      m_brk = 1;
    end else begin
      h = m_ext ? map_e[b] : map_n[b];
      if (h != 8'h00) begin
        if (!m_brk && exp_key != h) begin
          exp_key = h;
          e_press++;
        end else if (m_brk && exp_key == h) begin
          exp_key = 8'h00;
          e_rel++;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(bit b);
    ps2_dat = b;
    tick(5);
    ps2_clk = 1'b0;
    tick(10);
    ps2_clk = 1'b1;
    tick(5);
  endtask

  task automatic chk_counts(string tag);
    chk({tag, "_press"}, n_press, e_press);
    chk({tag, "_rel"}, n_rel, e_rel);
    chk({tag, "_perr"}, n_perr, e_perr);
    chk({tag, "_ferr"}, n_ferr, e_ferr);
  endtask

  task automatic send_frame(logic [7:0] b, bit pbad = 0, bit sbad = 0);
    logic [7:0] prev;
    logic [9:0] bits;
    prev = exp_key;
    model_step(b, pbad, sbad);
    bits = {(~^b) ^ pbad, b, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    // Stop bit: keycode must move exactly 4 Clk edges after PS2_CLK falls.
    ps2_dat = ~sbad;
    tick(5);
    ps2_clk = 1'b0;
    tick(3);
    chk("lat_pre", keycode, prev);
    tick(1);
    chk("lat", keycode, exp_key);
    tick(6);
    ps2_clk = 1'b1;
    tick(10);
    chk_counts("frm");
  endtask

  logic [7:0] norm [9] = '{8'h0D, 8'h15, 8'h1C, 8'h23, 8'h1D,
                           8'h1B, 8'h29, 8'h5A, 8'h76};
  logic [7:0] extc [4] = '{8'h6B, 8'h74, 8'h75, 8'h72};

  initial begin
    logic [7:0] b;
    int r;
    init_maps();

    // Power-on reset
    tick(3);
    chk("rst_key", keycode, 8'h00);
    chk("rst_press", key_press, 1'b0);
    chk("rst_rel", key_release, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    rst_n = 1'b1;
    tick(5);

    // Reset in the middle of a frame
    send_frame(8'h1C);
    chk("pre_rst", keycode, 8'h04);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_key", keycode, 8'h00);
    chk("mid_rst_press", key_press, 1'b0);
    tick(3);
    rst_n = 1'b1;
    exp_key = 8'h00;
    m_ext = 0;
    m_brk = 0;
    tick(5);
    send_frame(8'h0D);
    chk("tab", keycode, 8'h2B);
    send_frame(8'hF0);
    send_frame(8'h0D);
    chk("tab_rel", keycode, 8'h00);

    // Make, typematic repeat, break
    send_frame(8'h15);
    send_frame(8'h15);
    chk("q_rep", keycode, 8'h14);
    send_frame(8'hF0);
    send_frame(8'h15);
    chk("q_rel", keycode, 8'h00);

    // Extended keys
    send_frame(8'hE0);
    send_frame(8'h6B);
    chk("left", keycode, 8'h50);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h6B);
    chk("left_rel", keycode, 8'h00);
    send_frame(8'h6B);
    chk("bare_6b", keycode, 8'h00);

    // Overlapping keys
    send_frame(8'h1C);
    send_frame(8'h23);
    chk("d_over", keycode, 8'h07);
    send_frame(8'hF0);
    send_frame(8'h1C);
    chk("a_rel_old", keycode, 8'h07);
    send_frame(8'hF0);
    send_frame(8'h23);
    chk("d_rel", keycode, 8'h00);

    // Frame errors
    send_frame(8'h0D, 1, 0);
    send_frame(8'h0D, 0, 1);
    send_frame(8'h0D, 1, 1);
    chk("err_key", keycode, 8'h00);

    // Timeout mid-frame clears a pending break prefix
    send_frame(8'hF0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    tick(TMO - 100);
    chk("tmo_early", n_ferr, e_ferr);
    tick(150);
    e_ferr++;
    m_ext = 0;
    m_brk = 0;
    chk("tmo_ferr", n_ferr, e_ferr);
    chk("tmo_key", keycode, exp_key);
    send_frame(8'h0D);
    chk("after_tmo", keycode, 8'h2B);

    // Random scancode stream
    for (int n = 0; n < 90; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 8: b = norm[$urandom_range(0, 8)];
        4:             b = extc[$urandom_range(0, 3)];
        5:             b = 8'hE0;
        6, 7:          b = 8'hF0;
        default:       b = 8'($urandom);
      endcase
      send_frame(b, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 19) == 0);
    end
    chk_counts("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
